// File: rtl/regfile_dump_reader.sv
// Sequencer that dumps every register-file word as an (address, data) beat
// on a valid/ready stream, followed by one XOR checksum beat.
module regfile_dump_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, CSUM} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] csum;
    logic              handshake;

    // The read port follows the word counter directly so the file sees a stable
    // address for the whole time a word is held in SEND.
    assign rd_addr   = cnt;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            csum      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        csum  <= '0;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_addr  <= cnt;
                    csum      <= csum ^ rd_data;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (cnt == LAST_ADDR) begin
                            // csum already folds in the last word; keep valid high
                            // so the checksum beat follows with no gap.
                            out_data <= csum;
                            out_addr <= '0;
                            out_last <= 1'b1;
                            state    <= CSUM;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            out_valid <= 1'b0;
                            state     <= READ;
                        end
                    end
                end
                CSUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats come from a snapshot
// of the register model at start; a negedge monitor pops and compares.
module tb_regfile_dump_reader;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, outReady = 1'b0;
    logic busy, outValid, outLast, done;
    logic [ADDR_W-1:0] rdAddr, outAddr;
    logic [DATA_W-1:0] rdData, outData;
    logic [DATA_W-1:0] regs [DEPTH];

    int checks = 0, errors = 0;
    int beatCnt = 0, doneCnt = 0, beatBase = 0, doneBase = 0;
    beat_t expQ[$];

    assign rdData = regs[rdAddr];
    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_addr(rdAddr), .rd_data(rdData),
        .out_valid(outValid), .out_ready(outReady),
        .out_addr(outAddr), .out_data(outData), .out_last(outLast), .done(done)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: words in address order, then the XOR of all of them.
    function automatic void pushDump();
        beat_t b;
        logic [DATA_W-1:0] x = '0;
        for (int a = 0; a < DEPTH; a++) begin
            b.addr = ADDR_W'(a); b.data = regs[a]; b.last = 1'b0;
            expQ.push_back(b);
            x ^= regs[a];
        end
        b.addr = '0; b.data = x; b.last = 1'b1;
        expQ.push_back(b);
    endfunction

    // Monitor: compare accepted beats, and check that a stalled beat stays put.
    beat_t held;
    logic [ADDR_W-1:0] heldRd;
    bit holdPending = 0;
    always @(negedge clk) begin
        if (reset) begin
            holdPending = 0;
        end else begin
            if (holdPending) begin
                check("hold_valid", int'(outValid), 1);
                check("hold_addr", int'(outAddr), int'(held.addr));
                check("hold_data", int'(outData), int'(held.data));
                check("hold_last", int'(outLast), int'(held.last));
                check("hold_rdaddr", int'(rdAddr), int'(heldRd));
            end
            if (outValid && outReady) begin
                beat_t e;
                beatCnt++;
                holdPending = 0;
                if (expQ.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("beat_addr", int'(outAddr), int'(e.addr));
                    check("beat_data", int'(outData), int'(e.data));
                    check("beat_last", int'(outLast), int'(e.last));
                end
            end else if (outValid) begin
                holdPending = 1;
                held.addr = outAddr; held.data = outData; held.last = outLast;
                heldRd = rdAddr;
            end else begin
                holdPending = 0;
            end
            if (done) doneCnt++;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Returns at the negedge where the requested data word is presented.
    task automatic waitValid(input int a);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (outValid && !outLast && int'(outAddr) == a) return;
        end
        check("wait_valid_timeout", 0, 1);
    endtask

    task automatic pass(input int a);
        waitValid(a);
        cyc(); outReady = 1'b1;
        cyc(); outReady = 1'b0;
    endtask

    // Returns at the negedge where done is high.
    task automatic waitDone(input bit rnd);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) return;
            cyc();
            if (rnd) outReady = 1'($urandom_range(0, 1));
        end
        check("wait_done_timeout", 0, 1);
    endtask

    task automatic mark();
        beatBase = beatCnt; doneBase = doneCnt;
    endtask

    task automatic checkCounts(input string tag, input int beats, input int dones);
        cyc();
        check({tag, "_beats"}, beatCnt - beatBase, beats);
        check({tag, "_dones"}, doneCnt - doneBase, dones);
        check({tag, "_queue_empty"}, expQ.size(), 0);
    endtask

    task automatic setRegs(input logic [DATA_W-1:0] r0, r1, r2, r3);
        regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
    endtask

    task automatic bpDump(input bit doWrite);
        setRegs(4'h3, 4'hA, 4'h5, 4'h0);
        outReady = 1'b0;
        mark(); pushDump(); pulseStart();
        pass(0);
        waitValid(1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            if (doWrite && i == 0) regs[1] = 4'hF;
            check("bp_data", int'(outData), 'hA);
            check("bp_addr", int'(outAddr), 1);
            check("bp_rdaddr", int'(rdAddr), 1);
            cyc();
        end
        outReady = 1'b1;
        waitDone(0);
        checkCounts(doWrite ? "write_during_send" : "backpressure", DEPTH + 1, 1);
    endtask

    initial begin
        int n, busyCnt;
        setRegs(4'h0, 4'h0, 4'h0, 4'h0);
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_rdaddr", int'(rdAddr), 0);
        check("rst_valid", int'(outValid), 0);
        check("rst_addr", int'(outAddr), 0);
        check("rst_data", int'(outData), 0);
        check("rst_last", int'(outLast), 0);
        check("rst_done", int'(done), 0);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Basic dump with latency and busy-length checks.
        setRegs(4'h3, 4'hA, 4'h5, 4'h0);
        outReady = 1'b1;
        mark(); pushDump();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busyCnt++;
            @(posedge clk);
            n++;
        end
        check("done_latency", n, 2 * DEPTH + 1);
        check("busy_cycles", busyCnt, 2 * DEPTH + 1);
        check("busy_at_done", int'(busy), 0);
        checkCounts("basic", DEPTH + 1, 1);

        bpDump(0);
        bpDump(1);

        // Reset while word 2 is presented.
        setRegs(4'h3, 4'hA, 4'h5, 4'h0);
        outReady = 1'b0;
        mark(); pushDump(); pulseStart();
        pass(0); pass(1);
        waitValid(2);
        cyc();
        reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(outValid), 0);
        check("midrst_data", int'(outData), 0);
        check("midrst_addr", int'(outAddr), 0);
        check("midrst_rdaddr", int'(rdAddr), 0);
        check("midrst_last", int'(outLast), 0);
        check("midrst_done", int'(done), 0);
        expQ.delete();
        cyc(); cyc();
        reset = 1'b0;
        outReady = 1'b1;
        mark();
        repeat (10) cyc();
        checkCounts("post_reset_quiet", 0, 0);
        setRegs(4'h6, 4'h1, 4'h9, 4'hC);
        mark(); pushDump(); pulseStart();
        waitDone(0);
        checkCounts("post_reset_dump", DEPTH + 1, 1);

        // Start while busy is ignored.
        setRegs(4'h3, 4'hA, 4'h5, 4'h0);
        mark(); pushDump(); pulseStart();
        waitValid(1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        waitDone(0);
        repeat (12) cyc();
        checkCounts("start_while_busy", DEPTH + 1, 1);

        // All zeros, then start in the done cycle.
        setRegs(4'h0, 4'h0, 4'h0, 4'h0);
        mark(); pushDump(); pulseStart();
        waitDone(0);
        setRegs(4'h7, 4'h2, 4'hE, 4'h4);
        pushDump();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_busy", int'(busy), 1);
        waitDone(0);
        checkCounts("back_to_back", 2 * (DEPTH + 1), 2);

        // Random contents with random backpressure.
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < DEPTH; a++) regs[a] = DATA_W'($urandom);
            repeat ($urandom_range(0, 3)) cyc();
            mark(); pushDump(); pulseStart();
            waitDone(1);
            outReady = 1'b1;
            checkCounts("random", DEPTH + 1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
